// File: rtl/custominst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : custominst_sequencer
// Brief    : Multi-cycle sequencer for custom FFT / XOR-crypt instructions
//            over a single-port data memory, with readback of mem[r1].
// Revision : 1.0 - initial release
// ============================================================================
module custominst_sequencer #(
    parameter logic [18:0] KEY       = 19'h55555,
    parameter int          BLOCK_LEN = 8,
    parameter int          AW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [AW-1:0] req_r1,
    input  logic [AW-1:0] req_r2,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [18:0]   mem_wdata,
    input  logic [18:0]   mem_rdata,
    output logic [15:0]   fft_x0real,
    output logic [15:0]   fft_x0imag,
    output logic [15:0]   fft_x1real,
    output logic [15:0]   fft_x1imag,
    input  logic [15:0]   fft_y0real,
    input  logic [15:0]   fft_y0imag,
    input  logic [15:0]   fft_y1real,
    input  logic [15:0]   fft_y1imag,
    output logic          busy,
    output logic          done,
    output logic [18:0]   dataout
);

    localparam int c_CW = ($clog2(BLOCK_LEN) > 2) ? $clog2(BLOCK_LEN) : 2;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FFT_RD  = 3'd1;
    localparam logic [2:0] S_FFT_CAP = 3'd2;
    localparam logic [2:0] S_FFT_WR  = 3'd3;
    localparam logic [2:0] S_XOR_RD  = 3'd4;
    localparam logic [2:0] S_XOR_WR  = 3'd5;
    localparam logic [2:0] S_RB_RD   = 3'd6;
    localparam logic [2:0] S_RB_CAP  = 3'd7;

    localparam logic [1:0] c_OP_FFT = 2'b00;
    localparam logic [1:0] c_OP_NOP = 2'b11;

    localparam logic [c_CW-1:0] c_CNT_FFT_LAST = c_CW'(3);
    localparam logic [c_CW-1:0] c_CNT_XOR_LAST = c_CW'(BLOCK_LEN - 1);

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic [1:0]      r_op;
    logic [AW-1:0]   r_r1;
    logic [AW-1:0]   r_r2;
    logic [15:0]     r_x0real;
    logic [15:0]     r_x0imag;
    logic [15:0]     r_x1real;
    logic [15:0]     r_x1imag;
    logic            r_done;
    logic [18:0]     r_dataout;
    logic [AW-1:0]   w_rd_addr;
    logic [AW-1:0]   w_wr_addr;

    assign w_rd_addr = r_r2 + AW'(r_cnt);
    assign w_wr_addr = r_r1 + AW'(r_cnt);

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign dataout    = r_dataout;
    assign fft_x0real = r_x0real;
    assign fft_x0imag = r_x0imag;
    assign fft_x1real = r_x1real;
    assign fft_x1imag = r_x1imag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_cnt_nxt = '0;
                    case (req_op)
                        c_OP_FFT: w_state_nxt = S_FFT_RD;
                        // Nop borrows the readback capture cycle; dataout is forced to 0 there.
                        c_OP_NOP: w_state_nxt = S_RB_CAP;
                        default:  w_state_nxt = S_XOR_RD;
                    endcase
                end
            end
            S_FFT_RD: begin
                mem_addr = w_rd_addr;
                if (r_cnt == c_CNT_FFT_LAST) begin
                    w_state_nxt = S_FFT_CAP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_FFT_CAP: begin
                w_state_nxt = S_FFT_WR;
            end
            S_FFT_WR: begin
                mem_addr = w_wr_addr;
                mem_we   = 1'b1;
                case (r_cnt[1:0])
                    2'd0:    mem_wdata = {3'b000, fft_y0real};
                    2'd1:    mem_wdata = {3'b000, fft_y0imag};
                    2'd2:    mem_wdata = {3'b000, fft_y1real};
                    default: mem_wdata = {3'b000, fft_y1imag};
                endcase
                if (r_cnt == c_CNT_FFT_LAST) begin
                    w_state_nxt = S_RB_RD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_XOR_RD: begin
                mem_addr    = w_rd_addr;
                w_state_nxt = S_XOR_WR;
            end
            S_XOR_WR: begin
                mem_addr  = w_wr_addr;
                mem_we    = 1'b1;
                mem_wdata = mem_rdata ^ KEY;
                if (r_cnt == c_CNT_XOR_LAST) begin
                    w_state_nxt = S_RB_RD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = S_XOR_RD;
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            S_RB_RD: begin
                mem_addr    = r_r1;
                w_state_nxt = S_RB_CAP;
            end
            S_RB_CAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_r1      <= '0;
            r_r2      <= '0;
            r_x0real  <= '0;
            r_x0imag  <= '0;
            r_x1real  <= '0;
            r_x1imag  <= '0;
            r_done    <= 1'b0;
            r_dataout <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE && req_valid) begin
                r_op <= req_op;
                r_r1 <= req_r1;
                r_r2 <= req_r2;
            end
            // Read data lags the address by one cycle, so word k lands while r_cnt == k+1.
            if (r_state == S_FFT_RD) begin
                case (r_cnt[1:0])
                    2'd1:    r_x0real <= mem_rdata[15:0];
                    2'd2:    r_x0imag <= mem_rdata[15:0];
                    2'd3:    r_x1real <= mem_rdata[15:0];
                    default: ;
                endcase
            end
            if (r_state == S_FFT_CAP) begin
                r_x1imag <= mem_rdata[15:0];
            end
            if (r_state == S_RB_CAP) begin
                r_done    <= 1'b1;
                r_dataout <= (r_op == c_OP_NOP) ? '0 : mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_custominst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_custominst_sequencer
// Brief    : Self-checking bench: memory + butterfly models, vector table,
//            done/dataout scoreboard and multi-cycle corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_custominst_sequencer;

    localparam logic [18:0] c_KEY = 19'h55555;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [7:0]  req_r1;
    logic [7:0]  req_r2;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [18:0] mem_wdata;
    logic [18:0] mem_rdata;
    logic [15:0] fft_x0real, fft_x0imag, fft_x1real, fft_x1imag;
    logic [15:0] fft_y0real, fft_y0imag, fft_y1real, fft_y1imag;
    logic        busy;
    logic        done;
    logic [18:0] dataout;

    custominst_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_r1     (req_r1),
        .req_r2     (req_r2),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .fft_x0real (fft_x0real),
        .fft_x0imag (fft_x0imag),
        .fft_x1real (fft_x1real),
        .fft_x1imag (fft_x1imag),
        .fft_y0real (fft_y0real),
        .fft_y0imag (fft_y0imag),
        .fft_y1real (fft_y1real),
        .fft_y1imag (fft_y1imag),
        .busy       (busy),
        .done       (done),
        .dataout    (dataout)
    );

    // Butterfly: y0 = x0 + x1, y1 = x0 - x1 on real and imaginary parts.
    assign fft_y0real = fft_x0real + fft_x1real;
    assign fft_y0imag = fft_x0imag + fft_x1imag;
    assign fft_y1real = fft_x0real - fft_x1real;
    assign fft_y1imag = fft_x0imag - fft_x1imag;

    logic [18:0] mem     [256];
    logic [18:0] ref_mem [256];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
        cyc <= cyc + 1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] data;
        int          cyc;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  r1;
        logic [7:0]  r2;
        logic [18:0] exp_data;
        int          lat;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_mem(input string name);
        int bad = 0;
        int first = -1;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d words differ, first at 0x%02h got 0x%05h expected 0x%05h",
                     name, bad, first, mem[first], ref_mem[first]);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [18:0] d);
        mem[a]     = d;
        ref_mem[a] = d;
    endtask

    // Reference effect of one instruction on memory, returning mem[r1] afterwards.
    task automatic model_apply(input logic [1:0] op, input logic [7:0] r1, input logic [7:0] r2,
                               output logic [18:0] rb);
        logic [15:0] a, b, c, d;
        logic [7:0]  s, t;
        rb = '0;
        if (op == 2'b00) begin
            a = ref_mem[r2][15:0];
            s = r2 + 8'd1; b = ref_mem[s][15:0];
            s = r2 + 8'd2; c = ref_mem[s][15:0];
            s = r2 + 8'd3; d = ref_mem[s][15:0];
            ref_mem[r1] = {3'b000, a + c};
            s = r1 + 8'd1; ref_mem[s] = {3'b000, b + d};
            s = r1 + 8'd2; ref_mem[s] = {3'b000, a - c};
            s = r1 + 8'd3; ref_mem[s] = {3'b000, b - d};
            rb = ref_mem[r1];
        end else if (op != 2'b11) begin
            for (int i = 0; i < 8; i++) begin
                s = r2 + 8'(i);
                t = r1 + 8'(i);
                ref_mem[t] = ref_mem[s] ^ c_KEY;
            end
            rb = ref_mem[r1];
        end
    endtask

    // Drives one request from a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic [1:0] op, input logic [7:0] r1, input logic [7:0] r2,
                         output int acc);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: req_ready stayed 0 expected 1");
        end
        req_valid = 1'b1;
        req_op    = op;
        req_r1    = r1;
        req_r2    = r2;
        acc       = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_sb_empty(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d results pending expected 0", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 dataout=0x%05h expected no completion", dataout);
            end else begin
                automatic sb_t e = sb.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("dataout", {13'b0, dataout}, {13'b0, e.data});
            end
        end
    end

    initial begin
        int          acc;
        logic [18:0] rb;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_r1    = '0;
        req_r2    = '0;
        for (int i = 0; i < 256; i++) preload(8'(i), 19'h40000 | 19'(i));
        preload(8'h10, 19'd3); preload(8'h11, 19'd1); preload(8'h12, 19'd1); preload(8'h13, 19'd2);
        for (int i = 0; i < 8; i++) preload(8'h20 + 8'(i), 19'(i));
        preload(8'hFE, 19'd5); preload(8'hFF, 19'd7); preload(8'h00, 19'd2); preload(8'h01, 19'd3);
        preload(8'h30, 19'd3); preload(8'h31, 19'd1); preload(8'h32, 19'd1); preload(8'h33, 19'd2);

        vecs[0] = '{2'b00, 8'h40, 8'h10, 19'h00004, 11};
        vecs[1] = '{2'b01, 8'h80, 8'h20, 19'h55555, 18};
        vecs[2] = '{2'b10, 8'hA0, 8'h80, 19'h00000, 18};
        vecs[3] = '{2'b11, 8'h00, 8'h00, 19'h00000, 1};
        vecs[4] = '{2'b00, 8'hFD, 8'hFE, 19'h00007, 11};
        vecs[5] = '{2'b00, 8'h30, 8'h30, 19'h00004, 11};

        repeat (3) @(negedge clk);
        check("rst_busy",      {31'b0, busy},      32'd0);
        check("rst_ready",     {31'b0, req_ready}, 32'd1);
        check("rst_done",      {31'b0, done},      32'd0);
        check("rst_dataout",   {13'b0, dataout},   32'd0);
        check("rst_mem_we",    {31'b0, mem_we},    32'd0);
        check("rst_mem_addr",  {24'b0, mem_addr},  32'd0);
        check("rst_mem_wdata", {13'b0, mem_wdata}, 32'd0);
        check("rst_fft_x",     {fft_x0real | fft_x0imag | fft_x1real | fft_x1imag}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            model_apply(vecs[v].op, vecs[v].r1, vecs[v].r2, rb);
            issue(vecs[v].op, vecs[v].r1, vecs[v].r2, acc);
            sb.push_back('{vecs[v].exp_data, acc + 1 + vecs[v].lat});
            wait_sb_empty($sformatf("vec%0d", v));
            check_mem($sformatf("vec%0d_mem", v));
        end
        check("fft_y1imag_word", {13'b0, mem[8'h43]}, 32'h0FFFF);
        check("dec_word3",       {13'b0, mem[8'hA3]}, 32'h00003);
        check("wrap_word0",      {13'b0, mem[8'h00]}, 32'h00004);

        // Reset at E5 of an XOR: only words 0 and 1 may have landed.
        issue(2'b01, 8'hC0, 8'h20, acc);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy",    {31'b0, busy},    32'd0);
        check("abort_done",    {31'b0, done},    32'd0);
        check("abort_dataout", {13'b0, dataout}, 32'd0);
        check("abort_mem_we",  {31'b0, mem_we},  32'd0);
        rst = 1'b0;
        ref_mem[8'hC0] = 19'd0 ^ c_KEY;
        ref_mem[8'hC1] = 19'd1 ^ c_KEY;
        check_mem("abort_mem");
        issue(2'b11, 8'h00, 8'h00, acc);
        sb.push_back('{19'h00000, acc + 2});
        wait_sb_empty("after_abort");

        // Request held valid with another op while an FFT is running.
        model_apply(2'b00, 8'h50, 8'h10, rb);
        issue(2'b00, 8'h50, 8'h10, acc);
        sb.push_back('{rb, acc + 12});
        req_valid = 1'b1;
        req_op    = 2'b11;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("hold_ready", {31'b0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        wait_sb_empty("hold_fft");
        check_mem("hold_mem");

        // Back-to-back nops with valid held continuously.
        req_valid = 1'b1;
        req_op    = 2'b11;
        sb.push_back('{19'h00000, cyc + 2});
        @(negedge clk);
        check("b2b_ready_busy", {31'b0, req_ready}, 32'd0);
        check("b2b_busy",       {31'b0, busy},      32'd1);
        @(negedge clk);
        check("b2b_ready_done", {31'b0, req_ready}, 32'd1);
        sb.push_back('{19'h00000, cyc + 2});
        @(negedge clk);
        req_valid = 1'b0;
        wait_sb_empty("b2b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/custominst_sequencer.md
Name: custominst_sequencer

Overview:
Multi-cycle controller that executes custom instructions (2-point FFT, XOR encrypt, XOR decrypt) against a shared single-port 256x19 data memory and an external combinational 2-point FFT butterfly. It accepts one instruction at a time over a valid/ready handshake and sequences all memory reads and writes. It reads back memory[r1] after every operation and reports the result with a one-cycle done pulse. It sits between the instruction issue logic and the data memory/FFT datapath.

Parameters:
KEY, 19'h55555 (19'b1010101010101010101), XOR key for encrypt/decrypt
BLOCK_LEN, 8, words processed per encrypt/decrypt
AW, 8, memory address width; all address arithmetic is modulo 2^AW

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  instruction request
req_ready  out  1  high only in IDLE
req_op  in  2  00 FFT, 01 encrypt, 10 decrypt, 11 nop
req_r1  in  8  destination base address
req_r2  in  8  source base address
mem_addr  out  8  memory address (combinational from state/counter)
mem_we  out  1  write enable; commits mem_wdata at the next rising edge
mem_wdata  out  19  write data
mem_rdata  in  19  read data = mem[mem_addr] sampled at the previous edge (1-cycle latency)
fft_x0real, fft_x0imag, fft_x1real, fft_x1imag  out  16 each  registered butterfly inputs
fft_y0real, fft_y0imag, fft_y1real, fft_y1imag  in  16 each  butterfly outputs (combinational)
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when the operation completes
dataout  out  19  readback of memory[r1]; held until the next completion

Behaviour:
- Reset: state IDLE; done=0, dataout=0, mem_we=0, mem_addr=0, mem_wdata=0, fft_x*=0, counters=0. Reset mid-operation aborts immediately. Memory writes already committed remain. No done pulse is issued.
- Acceptance happens at edge E0 with req_valid & req_ready. op/r1/r2 are latched at E0. Request inputs are ignored while busy.
- States: IDLE, FFT_RD, FFT_CAP, FFT_WR, XOR_RD, XOR_WR, RB_RD, RB_CAP.
- FFT (op 00):
  - FFT_RD, 4 cycles: addresses r2, r2+1, r2+2, r2+3. Each word is captured in the following cycle into x0real, x0imag, x1real, x1imag using bits [15:0].
  - FFT_CAP, 1 cycle: captures the last word.
  - FFT_WR, 4 cycles: mem_we=1 to addresses r1..r1+3 with data {3'b0,y0real}, {3'b0,y0imag}, {3'b0,y1real}, {3'b0,y1imag}. fft_x* are held stable throughout.
  - All reads complete before any write, so in-place operation (r1==r2) is valid.
- Encrypt/decrypt (op 01/10): the operation is identical and self-inverse. For i = 0..BLOCK_LEN-1:
  - XOR_RD: addr r2+i.
  - XOR_WR: addr r1+i, mem_we=1, wdata = mem_rdata ^ KEY.
  - Ordering is strictly read i, write i, read i+1. Overlapping ranges therefore follow this order (e.g. r1=r2+1 propagates the XOR chain).
- Readback: RB_RD issues addr r1 with mem_we=0. RB_CAP sets dataout<=mem_rdata and done<=1, then returns to IDLE. dataout therefore reflects the newly written value.
- Nop (op 11): at E1, dataout<=0, done<=1, return to IDLE. No memory access.
- Latency (done visible after edge): FFT E11, XOR E18, nop E1. req_ready is high in the cycle done is high, so back-to-back acceptance is permitted.
- Address wrap: r+k wraps modulo 256 (0xFF+1 = 0x00).
- Outside write states: mem_we=0 and mem_wdata=0.

Test Plan:
- FFT: mem[0x10..0x13] = 3, 1, 1, 2; op00, r2=0x10, r1=0x40 -> mem[0x40..0x43] = 0x00004, 0x00003, 0x00002, 0x0FFFF; done at E11; dataout=0x00004.
- Encrypt: mem[0x20+i]=i for i=0..7; op01, r2=0x20, r1=0x80 -> mem[0x80+i] = i^0x55555; dataout=0x55555; done at E18. Then op10 with r2=0x80, r1=0xA0 -> mem[0xA0+i]=i.
- Wrap: op00 with r2=0xFE, r1=0xFD -> reads 0xFE, 0xFF, 0x00, 0x01; writes 0xFD, 0xFE, 0xFF, 0x00.
- Reset mid-XOR: assert rst at E5 -> next cycle busy=0, done=0, dataout=0, mem_we=0; only words 0-1 written. A new request is accepted afterwards.
- Handshake: req_valid held high during an FFT with a different op -> ignored until IDLE. op11 back-to-back -> done every other cycle, dataout=0.
- In-place FFT with r1=r2=0x30 -> results match the out-of-place case.
